// File: rtl/test_run_ctrl.sv
// rtl/test_run_ctrl.sv - test-run sequencer: DUT reset, case scheduling, per-case cycle count,
// run timeout and pass/fail tally for the tinyrv1 harness.
module test_run_ctrl #(
  parameter int RST_CYCLES = 3,
  parameter int TIMEOUT    = 10000,
  parameter int NCASES     = 8,
  parameter int CASE_W     = 4,
  parameter int CW         = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [CASE_W-1:0] sel_case,
  input  logic              case_done,
  input  logic              chk_valid,
  input  logic              chk_fail,
  output logic              dut_rst,
  output logic [CASE_W-1:0] case_id,
  output logic              case_active,
  output logic [CW-1:0]     cycles,
  output logic              case_failed,
  output logic [15:0]       n_fail,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic              timeout
);

  localparam int RCW = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RST,
    S_RUN,
    S_NEXT,
    S_DONE
  } state_t;

  state_t            state_q, state_d;
  logic [RCW-1:0]    rst_cnt_q, rst_cnt_d;
  logic              all_mode_q, all_mode_d;
  logic              sel_ok_q, sel_ok_d;
  logic              dut_rst_q, dut_rst_d;
  logic [CASE_W-1:0] case_id_q, case_id_d;
  logic              case_active_q, case_active_d;
  logic [CW-1:0]     cycles_q, cycles_d;
  logic              case_failed_q, case_failed_d;
  logic [15:0]       n_fail_q, n_fail_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              pass_q, pass_d;
  logic              timeout_q, timeout_d;

  always_comb begin
    state_d       = state_q;
    rst_cnt_d     = rst_cnt_q;
    all_mode_d    = all_mode_q;
    sel_ok_d      = sel_ok_q;
    case_id_d     = case_id_q;
    cycles_d      = cycles_q;
    case_failed_d = case_failed_q;
    n_fail_d      = n_fail_q;
    timeout_d     = timeout_q;

    unique case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          if (sel_case > CASE_W'(NCASES)) begin
            // Out-of-range selection goes straight to a failing verdict.
            state_d  = S_DONE;
            sel_ok_d = 1'b0;
          end else begin
            all_mode_d    = (sel_case == '0);
            case_id_d     = (sel_case == '0) ? CASE_W'(1) : sel_case;
            sel_ok_d      = 1'b1;
            n_fail_d      = '0;
            timeout_d     = 1'b0;
            cycles_d      = '0;
            case_failed_d = 1'b0;
            rst_cnt_d     = '0;
            state_d       = S_RST;
          end
        end
      end

      S_RST: begin
        if (rst_cnt_q == RCW'(RST_CYCLES - 1)) begin
          state_d = S_RUN;
        end else begin
          rst_cnt_d = rst_cnt_q + RCW'(1);
        end
      end

      S_RUN: begin
        cycles_d = cycles_q + CW'(1);
        if (chk_valid && chk_fail) begin
          case_failed_d = 1'b1;
          if (n_fail_q != 16'hFFFF) begin
            n_fail_d = n_fail_q + 16'd1;
          end
        end
        // A finishing case wins over a timeout landing on the same cycle.
        if (case_done) begin
          state_d = S_NEXT;
        end else if (cycles_d > CW'(TIMEOUT)) begin
          timeout_d = 1'b1;
          state_d   = S_DONE;
        end
      end

      S_NEXT: begin
        if (all_mode_q && (case_id_q < CASE_W'(NCASES))) begin
          case_id_d     = case_id_q + CASE_W'(1);
          cycles_d      = '0;
          case_failed_d = 1'b0;
          rst_cnt_d     = '0;
          state_d       = S_RST;
        end else begin
          state_d = S_DONE;
        end
      end

      default: state_d = S_IDLE;
    endcase

    // Outputs are registered versions of what the next state implies.
    dut_rst_d     = (state_d != S_RUN);
    case_active_d = (state_d == S_RUN);
    busy_d        = (state_d == S_RST) || (state_d == S_RUN) || (state_d == S_NEXT);
    done_d        = (state_d == S_DONE);
    pass_d        = (state_d == S_DONE) && sel_ok_d && (n_fail_d == '0) && !timeout_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= S_IDLE;
      rst_cnt_q     <= '0;
      all_mode_q    <= 1'b0;
      sel_ok_q      <= 1'b0;
      dut_rst_q     <= 1'b1;
      case_id_q     <= '0;
      case_active_q <= 1'b0;
      cycles_q      <= '0;
      case_failed_q <= 1'b0;
      n_fail_q      <= '0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      pass_q        <= 1'b0;
      timeout_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      rst_cnt_q     <= rst_cnt_d;
      all_mode_q    <= all_mode_d;
      sel_ok_q      <= sel_ok_d;
      dut_rst_q     <= dut_rst_d;
      case_id_q     <= case_id_d;
      case_active_q <= case_active_d;
      cycles_q      <= cycles_d;
      case_failed_q <= case_failed_d;
      n_fail_q      <= n_fail_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
      pass_q        <= pass_d;
      timeout_q     <= timeout_d;
    end
  end

  assign dut_rst     = dut_rst_q;
  assign case_id     = case_id_q;
  assign case_active = case_active_q;
  assign cycles      = cycles_q;
  assign case_failed = case_failed_q;
  assign n_fail      = n_fail_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign pass        = pass_q;
  assign timeout     = timeout_q;

endmodule

// File: tb/tb_test_run_ctrl.sv
// tb/tb_test_run_ctrl.sv - randomized bench for test_run_ctrl against a per-case run model.
module tb_test_run_ctrl;

  localparam int RST_CYCLES = 3;
  localparam int TIMEOUT    = 20;
  localparam int NCASES     = 3;
  localparam int CASE_W     = 4;
  localparam int CW         = 32;

  logic              clk = 1'b0;
  logic              rst;
  logic              start;
  logic [CASE_W-1:0] sel_case;
  logic              case_done;
  logic              chk_valid;
  logic              chk_fail;
  logic              dut_rst;
  logic [CASE_W-1:0] case_id;
  logic              case_active;
  logic [CW-1:0]     cycles;
  logic              case_failed;
  logic [15:0]       n_fail;
  logic              busy;
  logic              done;
  logic              pass;
  logic              timeout;

  int nvec = 0;
  int nerr = 0;
  int lens [1:NCASES];
  int fail_case;
  bit rnd_chk;

  test_run_ctrl #(
    .RST_CYCLES(RST_CYCLES), .TIMEOUT(TIMEOUT), .NCASES(NCASES), .CASE_W(CASE_W), .CW(CW)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .sel_case(sel_case), .case_done(case_done),
    .chk_valid(chk_valid), .chk_fail(chk_fail), .dut_rst(dut_rst), .case_id(case_id),
    .case_active(case_active), .cycles(cycles), .case_failed(case_failed), .n_fail(n_fail),
    .busy(busy), .done(done), .pass(pass), .timeout(timeout)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    start = 1'b0; case_done = 1'b0; chk_valid = 1'b0; chk_fail = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; clear_inputs(); sel_case = '0;
    tick(); tick();
    nvec++;
    if ({dut_rst, case_active, busy, done, pass, timeout, case_failed} !== 7'b1000000 ||
        cycles !== 0 || n_fail !== 0 || case_id !== 0) begin
      nerr++;
      $display("FAIL reset: dut_rst=%b act=%b busy=%b done=%b pass=%b to=%b cf=%b cyc=%0d nf=%0d id=%0d, want 1,0,0,0,0,0,0,0,0,0",
               dut_rst, case_active, busy, done, pass, timeout, case_failed, cycles, n_fail, case_id);
    end
    rst = 1'b0;
    tick(); tick();
    nvec++;
    if ({dut_rst, busy, done, pass} !== 4'b1000 || cycles !== 0) begin
      nerr++;
      $display("FAIL idle: dut_rst=%b busy=%b done=%b pass=%b cyc=%0d, want 1,0,0,0,0",
               dut_rst, busy, done, pass, cycles);
    end
  endtask

  // Model: each selected case shows RST_CYCLES reset cycles, then lens[c] RUN cycles
  // with cycles = 0..lens[c]-1, then one NEXT cycle; failures accumulate across the run.
  task automatic do_run(input int sel);
    int first, last, nf, rs;
    bit cf, v, f;
    first = (sel == 0) ? 1 : sel;
    last  = (sel == 0) ? NCASES : sel;
    nf = 0;
    start = 1'b1; sel_case = CASE_W'(sel);
    tick();
    clear_inputs();
    for (int c = first; c <= last; c++) begin
      cf = 1'b0; rs = 0;
      while (!case_active && rs < 10) begin
        nvec++;
        if ({dut_rst, busy, done, case_failed, timeout, pass} !== 6'b110000 ||
            case_id !== c || cycles !== 0 || n_fail !== nf) begin
          nerr++;
          $display("FAIL rst_phase c=%0d: rst=%b busy=%b done=%b cf=%b to=%b pass=%b id=%0d cyc=%0d nf=%0d, want 1,1,0,0,0,0 id=%0d cyc=0 nf=%0d",
                   c, dut_rst, busy, done, case_failed, timeout, pass, case_id, cycles, n_fail, c, nf);
        end
        chk_valid = 1'($urandom); chk_fail = 1'($urandom); case_done = 1'($urandom);
        sel_case = CASE_W'($urandom);
        tick();
        rs++;
      end
      clear_inputs();
      nvec++;
      if (rs !== RST_CYCLES) begin
        nerr++;
        $display("FAIL rst_len c=%0d: got %0d cycles, want %0d", c, rs, RST_CYCLES);
      end
      for (int k = 0; k < lens[c]; k++) begin
        nvec++;
        if ({dut_rst, case_active, busy, case_failed} !== {3'b011, cf} ||
            cycles !== k || n_fail !== nf || case_id !== c) begin
          nerr++;
          $display("FAIL run c=%0d k=%0d: rst=%b act=%b busy=%b cf=%b cyc=%0d nf=%0d id=%0d, want 0,1,1,%b cyc=%0d nf=%0d",
                   c, k, dut_rst, case_active, busy, case_failed, cycles, n_fail, case_id, cf, k, nf);
        end
        if (rnd_chk) begin
          v = 1'($urandom); f = 1'($urandom);
        end else begin
          v = (c == fail_case) && (k == 1); f = v;
        end
        chk_valid = v; chk_fail = f;
        case_done = (k == lens[c] - 1);
        start = 1'($urandom); sel_case = CASE_W'($urandom);
        tick();
        if (v && f) begin
          cf = 1'b1; nf++;
        end
      end
      clear_inputs();
      nvec++;
      if ({dut_rst, case_active, busy, done} !== 4'b1010 || cycles !== lens[c] ||
          case_failed !== cf || n_fail !== nf || case_id !== c) begin
        nerr++;
        $display("FAIL next c=%0d: rst=%b act=%b busy=%b done=%b cyc=%0d cf=%b nf=%0d id=%0d, want 1,0,1,0 cyc=%0d cf=%b nf=%0d",
                 c, dut_rst, case_active, busy, done, cycles, case_failed, n_fail, case_id, lens[c], cf, nf);
      end
      tick();
    end
    for (int r = 0; r < 2; r++) begin
      nvec++;
      if ({dut_rst, busy, done, case_active, timeout, pass} !== {4'b1010, 1'b0, nf == 0} ||
          case_id !== last || cycles !== lens[last] || n_fail !== nf) begin
        nerr++;
        $display("FAIL done sel=%0d r=%0d: rst=%b busy=%b done=%b act=%b to=%b pass=%b id=%0d cyc=%0d nf=%0d, want 1,0,1,0,0,%b id=%0d cyc=%0d nf=%0d",
                 sel, r, dut_rst, busy, done, case_active, timeout, pass, case_id, cycles, n_fail,
                 nf == 0, last, lens[last], nf);
      end
      tick();
    end
  endtask

  task automatic test_single();
    lens[2] = 5; rnd_chk = 1'b0; fail_case = 0;
    do_run(2);
  endtask

  task automatic test_all();
    lens[1] = 3; lens[2] = 4; lens[3] = 2; rnd_chk = 1'b0; fail_case = 0;
    do_run(0);
  endtask

  task automatic test_fail_case2();
    lens[1] = 3; lens[2] = 3; lens[3] = 3; rnd_chk = 1'b0; fail_case = 2;
    do_run(0);
  endtask

  task automatic test_done_beats_timeout();
    lens[1] = TIMEOUT + 1; rnd_chk = 1'b0; fail_case = 0;
    do_run(1);
  endtask

  task automatic test_timeout();
    int rs;
    start = 1'b1; sel_case = 4'd1;
    tick();
    clear_inputs();
    rs = 0;
    while (!case_active && rs < 10) begin
      tick();
      rs++;
    end
    nvec++;
    if (rs !== RST_CYCLES) begin
      nerr++;
      $display("FAIL to_rst_len: got %0d, want %0d", rs, RST_CYCLES);
    end
    for (int k = 0; k <= TIMEOUT; k++) begin
      nvec++;
      if (case_active !== 1'b1 || cycles !== k || timeout !== 1'b0) begin
        nerr++;
        $display("FAIL to_run k=%0d: act=%b cyc=%0d to=%b, want 1 cyc=%0d to=0", k, case_active, cycles, timeout, k);
      end
      tick();
    end
    for (int r = 0; r < 2; r++) begin
      nvec++;
      if ({done, timeout, pass, busy, case_active, dut_rst} !== 6'b110001 || cycles !== TIMEOUT + 1) begin
        nerr++;
        $display("FAIL to_done r=%0d: done=%b to=%b pass=%b busy=%b act=%b rst=%b cyc=%0d, want 1,1,0,0,0,1 cyc=%0d",
                 r, done, timeout, pass, busy, case_active, dut_rst, cycles, TIMEOUT + 1);
      end
      tick();
    end
  endtask

  task automatic test_invalid_sel();
    int sels [3] = '{5, NCASES + 1, 15};
    for (int i = 0; i < 3; i++) begin
      start = 1'b1; sel_case = CASE_W'(sels[i]);
      tick();
      start = 1'b0;
      for (int r = 0; r < 2; r++) begin
        nvec++;
        if ({done, pass, busy, dut_rst, case_active} !== 5'b10010) begin
          nerr++;
          $display("FAIL bad_sel sel=%0d r=%0d: done=%b pass=%b busy=%b rst=%b act=%b, want 1,0,0,1,0",
                   sels[i], r, done, pass, busy, dut_rst, case_active);
        end
        tick();
      end
    end
  endtask

  task automatic test_random_runs();
    int sel;
    rnd_chk = 1'b1; fail_case = 0;
    for (int i = 0; i < 8; i++) begin
      sel = $urandom_range(0, NCASES);
      for (int c = 1; c <= NCASES; c++) lens[c] = $urandom_range(1, 8);
      do_run(sel);
    end
  endtask

  task automatic test_rst_mid_run();
    start = 1'b1; sel_case = '0;
    tick();
    start = 1'b0; chk_valid = 1'b1; chk_fail = 1'b1;
    repeat (RST_CYCLES + 2) tick();
    nvec++;
    if (case_active !== 1'b1 || cycles !== 2 || n_fail !== 2) begin
      nerr++;
      $display("FAIL pre_rst: act=%b cyc=%0d nf=%0d, want 1 cyc=2 nf=2", case_active, cycles, n_fail);
    end
    rst = 1'b1; start = 1'b1;
    tick();
    nvec++;
    if ({dut_rst, case_active, busy, done, pass, timeout, case_failed} !== 7'b1000000 ||
        cycles !== 0 || n_fail !== 0 || case_id !== 0) begin
      nerr++;
      $display("FAIL mid_rst: rst=%b act=%b busy=%b done=%b pass=%b to=%b cf=%b cyc=%0d nf=%0d id=%0d, want 1,0,0,0,0,0,0,0,0,0",
               dut_rst, case_active, busy, done, pass, timeout, case_failed, cycles, n_fail, case_id);
    end
    rst = 1'b0;
    clear_inputs();
    tick();
    nvec++;
    if ({dut_rst, busy, done, case_active} !== 4'b1000) begin
      nerr++;
      $display("FAIL post_rst_idle: rst=%b busy=%b done=%b act=%b, want 1,0,0,0", dut_rst, busy, done, case_active);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single();
    test_all();
    test_fail_case2();
    test_single();
    test_timeout();
    test_single();
    test_done_beats_timeout();
    test_invalid_sel();
    test_random_runs();
    test_rst_mid_run();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
